spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter SPICLK_FREQ, default 25000000, SCLK frequency in Hz; DIV = CLK_FREQ/(2*SPICLK_FREQ) SHALL be an integer >= 1, elaboration error otherwise.
REQ-003 Parameter WORD_LENGTH, default 32, bits per transfer per channel.
REQ-004 Parameter N_CH, default 4, number of parallel MOSI/MISO lanes sharing cs and sclk.
REQ-005 Parameter MISO_DELAY, default 0, extra clk cycles between SCLK rise and MISO sampling, range 0..4*DIV.
REQ-006 Parameter CS_HIGH_CYCLES, default 2, minimum clk cycles cs stays high between transfers.
REQ-007 clk  in  1  system clock, all logic on rising edge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 data_in_v  in  1  transfer request, qualified by ready_out.
REQ-010 ready_out  out  1  block idle, request accepted.
REQ-011 data_in  in  N_CH*WORD_LENGTH  TX words, channel k in bits [k*WORD_LENGTH +: WORD_LENGTH].
REQ-012 data_out  out  N_CH*WORD_LENGTH  RX words, same packing.
REQ-013 data_out_v  out  1  one-cycle pulse, data_out valid.
REQ-014 cs  out  1  shared chip select, active-low.
REQ-015 sclk  out  1  shared SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-016 mosi  out  N_CH  per-lane serial out.
REQ-017 miso  in  N_CH  per-lane serial in.

Function
REQ-018 States SHALL be IDLE, LEAD, SHIFT, CS_HIGH; ready_out=1 only in IDLE.
REQ-019 data_in_v=1 with ready_out=1 SHALL latch data_in that cycle and enter LEAD next cycle; data_in_v outside IDLE SHALL be ignored.
REQ-020 LEAD: cs=0, sclk=0, mosi[k]=MSB of lane k, duration DIV cycles.
REQ-021 SHIFT: WORD_LENGTH SCLK periods, each DIV cycles high then DIV cycles low; mosi updates only on sclk falling transition, MSB first.
REQ-022 cs SHALL be low for exactly (2*WORD_LENGTH+1)*DIV cycles per transfer (130 at defaults) and output registered, glitch-free.
REQ-023 Bit n of each lane SHALL be sampled MISO_DELAY cycles after the cycle sclk rises for bit n; sampling continues into CS_HIGH if needed; samples after the last sclk edge still recorded.
REQ-024 data_out_v SHALL pulse one cycle after the final sample registers; data_out holds until next data_out_v.
REQ-025 CS_HIGH SHALL last max(CS_HIGH_CYCLES, cycles until data_out_v issued), then IDLE.
REQ-026 All lanes SHALL shift in lockstep; lane count has no effect on timing.

Reset
REQ-027 During reset: cs=1, sclk=0, mosi=0, ready_out=0, data_out_v=0, data_out=0, state IDLE.
REQ-028 Reset mid-transfer SHALL abort next cycle with no data_out_v pulse; ready_out=1 the first cycle after reset deasserts.

Structure
REQ-029 Package spi_master_pkg SHALL hold state enum, DIV computation function and parameter checks.
REQ-030 One sub-module spi_shift_lane (per-lane TX/RX shift register with delayed-sample enable), instantiated N_CH times by generate.

Verification
REQ-031 Defaults, miso=mosi loopback, data_in lanes 0xA5A50001/0x12345678/0xFFFFFFFF/0x00000000 -> data_out equal, cs low 130 cycles, 32 sclk rises, 40 ns period.
REQ-032 MISO_DELAY=3, miso model = mosi delayed 3 clk -> data_out equals data_in on all lanes.
REQ-033 data_in_v held high 3 transfers -> three transfers, cs high exactly 2 cycles between, three data_out_v pulses.
REQ-034 Reset at cycle 50 of transfer -> next cycle cs=1, sclk=0, mosi=0; no data_out_v; ready_out=1 after release.
REQ-035 WORD_LENGTH=16, SPICLK_FREQ=10000000 -> cs low 165 cycles, 16 sclk periods of 100 ns.
REQ-036 miso[3]=1 constant, others 0 -> lane 3 reads 0xFFFFFFFF, lanes 0-2 read 0.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and elaboration helpers for the multi-lane SPI master.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    CS_HIGH
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned spiclk_freq);
    if (spiclk_freq == 0) return 0;
    return clk_freq / (2 * spiclk_freq);
  endfunction

  function automatic bit params_ok(input int unsigned clk_freq,
                                   input int unsigned spiclk_freq,
                                   input int unsigned word_length,
                                   input int unsigned n_ch,
                                   input int unsigned miso_delay,
                                   input int unsigned cs_high_cycles);
    int unsigned div;
    div = calc_div(clk_freq, spiclk_freq);
    return (spiclk_freq != 0) && ((clk_freq % (2 * spiclk_freq)) == 0) &&
           (div >= 1) && (word_length >= 2) && (n_ch >= 1) &&
           (miso_delay <= 4 * div) && (cs_high_cycles >= 1);
  endfunction

endpackage

// File: rtl/spi_shift_lane.sv
// One SPI lane: MSB-first TX shifter and RX shifter driven by shared enables.
module spi_shift_lane #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic [WORD_LENGTH-1:0] i_tx_word,
  input  logic                   i_shift,
  input  logic                   i_sample,
  input  logic                   i_miso,
  output logic                   o_mosi,
  output logic [WORD_LENGTH-1:0] o_rx_nxt
);

  logic [WORD_LENGTH-1:0] r_tx;
  logic [WORD_LENGTH-2:0] r_rx;

  // Zero fill on shift leaves mosi low once the word has gone out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load)       r_tx <= i_tx_word;
      else if (i_shift) r_tx <= {r_tx[WORD_LENGTH-2:0], 1'b0};
      if (i_sample)     r_rx <= o_rx_nxt[WORD_LENGTH-2:0];
    end
  end

  assign o_mosi   = r_tx[WORD_LENGTH-1];
  assign o_rx_nxt = {r_rx, i_miso};

endmodule

// File: rtl/spi_master_multi.sv
// Mode-0 SPI master driving N_CH parallel MOSI/MISO lanes on a shared cs/sclk.
module spi_master_multi
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned SPICLK_FREQ    = 25000000,
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned N_CH           = 4,
  parameter int unsigned MISO_DELAY     = 0,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_in_v,
  output logic                          ready_out,
  input  logic [N_CH*WORD_LENGTH-1:0]   data_in,
  output logic [N_CH*WORD_LENGTH-1:0]   data_out,
  output logic                          data_out_v,
  output logic                          cs,
  output logic                          sclk,
  output logic [N_CH-1:0]               mosi,
  input  logic [N_CH-1:0]               miso
);

  localparam int unsigned DIV     = calc_div(CLK_FREQ, SPICLK_FREQ);
  // The accepting IDLE cycle is part of the cs-high gap, so CS_HIGH is one shorter.
  localparam int unsigned CSH_TGT = (CS_HIGH_CYCLES > 1) ? CS_HIGH_CYCLES - 2 : 0;
  localparam int unsigned CNT_MAX = (DIV > CSH_TGT) ? DIV : CSH_TGT + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(WORD_LENGTH + 1);
  localparam int unsigned PIPE_W  = MISO_DELAY + 1;
  localparam int unsigned DATA_W  = N_CH * WORD_LENGTH;

  if (!params_ok(CLK_FREQ, SPICLK_FREQ, WORD_LENGTH, N_CH, MISO_DELAY, CS_HIGH_CYCLES)) begin : g_bad_params
    $error("spi_master_multi: illegal parameter combination");
  end

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic               r_half, w_half_nxt;
  logic               w_accept, w_sclk_nxt, w_cs_nxt, w_rise_nxt, w_fall_nxt;
  logic               r_cs, r_sclk, r_ready, r_dv, r_busy;
  logic [PIPE_W-1:0]  r_pipe;
  logic [BIT_W-1:0]   r_nsmp;
  logic               w_smp_en;
  logic [DATA_W-1:0]  w_rx_nxt, r_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_half  <= w_half_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_half_nxt  = r_half;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_in_v && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = LEAD;
          w_cnt_nxt   = '0;
        end
      end
      LEAD: begin
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_half_nxt  = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        // r_half=0 is the sclk-high half of a bit, r_half=1 the low half.
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_cnt_nxt = '0;
          if (!r_half) begin
            w_half_nxt = 1'b1;
          end else if (r_bit == BIT_W'(WORD_LENGTH - 1)) begin
            w_state_nxt = CS_HIGH;
          end else begin
            w_bit_nxt  = r_bit + BIT_W'(1);
            w_half_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      CS_HIGH: begin
        if (r_cnt == CNT_W'(CSH_TGT)) begin
          if (!r_busy) w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_cs_nxt   = !((w_state_nxt == LEAD) || (w_state_nxt == SHIFT));
    w_sclk_nxt = (w_state_nxt == SHIFT) && !w_half_nxt;
    w_rise_nxt = w_sclk_nxt && !r_sclk;
    w_fall_nxt = !w_sclk_nxt && r_sclk;
  end

  // Registered pins aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_ready <= 1'b0;
      r_pipe  <= '0;
    end else begin
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_pipe  <= (r_pipe << 1) | PIPE_W'(w_rise_nxt);
    end
  end

  assign w_smp_en = r_pipe[MISO_DELAY] && r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_nsmp <= '0;
      r_dv   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_dv <= 1'b0;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_nsmp <= '0;
      end else if (w_smp_en) begin
        if (r_nsmp == BIT_W'(WORD_LENGTH - 1)) begin
          r_busy <= 1'b0;
          r_dv   <= 1'b1;
          r_dout <= w_rx_nxt;
        end else begin
          r_nsmp <= r_nsmp + BIT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    spi_shift_lane #(
      .WORD_LENGTH(WORD_LENGTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_accept),
      .i_tx_word (data_in[k*WORD_LENGTH +: WORD_LENGTH]),
      .i_shift   (w_fall_nxt),
      .i_sample  (w_smp_en),
      .i_miso    (miso[k]),
      .o_mosi    (mosi[k]),
      .o_rx_nxt  (w_rx_nxt[k*WORD_LENGTH +: WORD_LENGTH])
    );
  end

  assign cs         = r_cs;
  assign sclk       = r_sclk;
  assign ready_out  = r_ready;
  assign data_out_v = r_dv;
  assign data_out   = r_dout;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: three configurations checked against a slave/loopback model.
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   v;
  logic [127:0] din0, din1;
  logic [63:0]  din2;
  wire  [127:0] dout0, dout1;
  wire  [63:0]  dout2;
  wire  [2:0]   rdy, dv, cs, sclk;
  wire  [3:0]   mosi0, mosi1, mosi2;
  logic [1:0]   mode;
  logic [3:0]   slave_miso, const_miso;
  logic [11:0]  dly1;
  wire  [3:0]   miso0 = (mode == 2'd0) ? mosi0 : (mode == 2'd1) ? slave_miso : const_miso;
  wire  [3:0]   miso1 = dly1[11:8];

  int n_cmp = 0;
  int n_err = 0;

  spi_master_multi u_dut0 (
    .clk(clk), .reset(reset), .data_in_v(v[0]), .ready_out(rdy[0]), .data_in(din0),
    .data_out(dout0), .data_out_v(dv[0]), .cs(cs[0]), .sclk(sclk[0]), .mosi(mosi0), .miso(miso0));

  spi_master_multi #(.MISO_DELAY(3)) u_dut1 (
    .clk(clk), .reset(reset), .data_in_v(v[1]), .ready_out(rdy[1]), .data_in(din1),
    .data_out(dout1), .data_out_v(dv[1]), .cs(cs[1]), .sclk(sclk[1]), .mosi(mosi1), .miso(miso1));

  spi_master_multi #(.WORD_LENGTH(16), .SPICLK_FREQ(10000000)) u_dut2 (
    .clk(clk), .reset(reset), .data_in_v(v[2]), .ready_out(rdy[2]), .data_in(din2),
    .data_out(dout2), .data_out_v(dv[2]), .cs(cs[2]), .sclk(sclk[2]), .mosi(mosi2), .miso(mosi2));

  // miso of the delayed instance is its own mosi seen three clocks late
  always @(posedge clk) dly1 <= {dly1[7:0], mosi1};

  // Bus monitor: cs-low length, sclk rises and rise-to-rise spacing per instance
  int cyc = 0;
  int low_cnt[3], last_low[3], rises[3], last_rises[3], last_rise_t[3];
  int per_min[3], per_max[3], hi_cnt[3], dv_cnt[3];
  int gaps[$];
  logic [2:0] pcs = 3'b111, psclk = 3'b000;

  always @(negedge clk) begin
    int p;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (cs[i] === 1'b0) begin
        if (pcs[i]) begin
          if (i == 0) gaps.push_back(hi_cnt[0]);
          hi_cnt[i] = 0; low_cnt[i] = 0; rises[i] = 0;
          per_min[i] = 1000000; per_max[i] = 0;
        end
        low_cnt[i]++;
        if (sclk[i] && !psclk[i]) begin
          rises[i]++;
          if (rises[i] > 1) begin
            p = cyc - last_rise_t[i];
            if (p < per_min[i]) per_min[i] = p;
            if (p > per_max[i]) per_max[i] = p;
          end
          last_rise_t[i] = cyc;
        end
      end else begin
        if (!pcs[i]) begin
          last_low[i] = low_cnt[i];
          last_rises[i] = rises[i];
        end
        hi_cnt[i]++;
      end
      if (dv[i] === 1'b1) dv_cnt[i]++;
    end
    pcs = cs;
    psclk = sclk;
  end

  // Mode-0 SPI slave on instance 0: shifts out on sclk fall, captures mosi on rise
  logic [31:0] s_word[4], s_rx[4];
  int   s_idx = 31;
  logic s_prev = 1'b0;

  always @(negedge clk) begin
    if (cs[0] !== 1'b0) begin
      s_idx = 31;
      s_prev = 1'b0;
    end else begin
      if (sclk[0] && !s_prev)
        for (int k = 0; k < 4; k++) s_rx[k] = {s_rx[k][30:0], mosi0[k]};
      if (!sclk[0] && s_prev && s_idx > 0) s_idx--;
      s_prev = sclk[0];
    end
    for (int k = 0; k < 4; k++) slave_miso[k] = s_word[k][s_idx];
  end

  task automatic xfer(input int d, input logic [127:0] din, output logic [127:0] dout);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (rdy[d] !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait dut%0d: ready_out=%b required 1", d, rdy[d]);
    end
    if (d == 0) din0 = din;
    else if (d == 1) din1 = din;
    else din2 = din[63:0];
    v[d] = 1'b1;
    @(negedge clk);
    v[d] = 1'b0;
    n = 0;
    while (!dv[d] && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (dv[d] !== 1'b1) begin
      n_err++;
      $display("FAIL dv_wait dut%0d: data_out_v=%b required 1", d, dv[d]);
    end
    dout = (d == 0) ? dout0 : (d == 1) ? dout1 : {64'h0, dout2};
    n = 0;
    while (!rdy[d] && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v = 3'b000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cs !== 3'b111 || sclk !== 3'b000) begin
      n_err++;
      $display("FAIL reset_pins: cs=%b sclk=%b required cs=111 sclk=000", cs, sclk);
    end
    n_cmp++;
    if ({mosi0, mosi1, mosi2} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mosi: got %h required 000", {mosi0, mosi1, mosi2});
    end
    n_cmp++;
    if (rdy !== 3'b000 || dv !== 3'b000) begin
      n_err++;
      $display("FAIL reset_handshake: ready=%b dv=%b required 000/000", rdy, dv);
    end
    n_cmp++;
    if (dout0 !== 128'h0 || dout2 !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data_out: got %h / %h required 0", dout0, dout2);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdy !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b required 111", rdy);
    end
  endtask

  task automatic test_loopback_fixed();
    logic [127:0] din, dout;
    mode = 2'd0;
    din = {32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'hA5A50001};
    xfer(0, din, dout);
    n_cmp++;
    if (dout !== din) begin
      n_err++;
      $display("FAIL loop_fixed_data: got %h required %h", dout, din);
    end
    n_cmp++;
    if (last_low[0] != 130 || last_rises[0] != 32) begin
      n_err++;
      $display("FAIL loop_fixed_timing: cs_low=%0d rises=%0d required 130/32", last_low[0], last_rises[0]);
    end
    n_cmp++;
    if (per_min[0] != 4 || per_max[0] != 4) begin
      n_err++;
      $display("FAIL loop_fixed_period: min=%0d max=%0d cycles required 4", per_min[0], per_max[0]);
    end
  endtask

  task automatic test_loopback_random();
    logic [127:0] din, dout;
    mode = 2'd0;
    for (int t = 0; t < 4; t++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      xfer(0, din, dout);
      n_cmp++;
      if (dout !== din) begin
        n_err++;
        $display("FAIL loop_rand_%0d: got %h required %h", t, dout, din);
      end
    end
  endtask

  task automatic test_slave_random();
    logic [127:0] din, dout, exp_rx, got_tx;
    mode = 2'd1;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) s_word[k] = $urandom;
      exp_rx = {s_word[3], s_word[2], s_word[1], s_word[0]};
      din = {$urandom, $urandom, $urandom, $urandom};
      xfer(0, din, dout);
      got_tx = {s_rx[3], s_rx[2], s_rx[1], s_rx[0]};
      n_cmp++;
      if (dout !== exp_rx) begin
        n_err++;
        $display("FAIL slave_rx_%0d: got %h required %h", t, dout, exp_rx);
      end
      n_cmp++;
      if (got_tx !== din) begin
        n_err++;
        $display("FAIL slave_tx_%0d: slave saw %h required %h", t, got_tx, din);
      end
    end
  endtask

  task automatic test_miso_delay();
    logic [127:0] din, dout;
    for (int t = 0; t < 3; t++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      xfer(1, din, dout);
      n_cmp++;
      if (dout !== din || last_low[1] != 130) begin
        n_err++;
        $display("FAIL delay3_%0d: got %h cs_low=%0d required %h / 130", t, dout, last_low[1], din);
      end
    end
  endtask

  task automatic test_word16();
    logic [127:0] din, dout;
    for (int t = 0; t < 2; t++) begin
      din = {64'h0, $urandom, $urandom};
      xfer(2, din, dout);
      n_cmp++;
      if (dout !== din) begin
        n_err++;
        $display("FAIL w16_data_%0d: got %h required %h", t, dout[63:0], din[63:0]);
      end
      n_cmp++;
      if (last_low[2] != 165 || last_rises[2] != 16 || per_min[2] != 10 || per_max[2] != 10) begin
        n_err++;
        $display("FAIL w16_timing_%0d: cs_low=%0d rises=%0d per=%0d..%0d required 165/16/10",
                 t, last_low[2], last_rises[2], per_min[2], per_max[2]);
      end
    end
  endtask

  task automatic test_const_miso();
    logic [127:0] din, dout, exp;
    mode = 2'd2;
    const_miso = 4'b1000;
    exp = {32'hFFFFFFFF, 96'h0};
    din = {$urandom, $urandom, $urandom, $urandom};
    xfer(0, din, dout);
    n_cmp++;
    if (dout !== exp) begin
      n_err++;
      $display("FAIL const_miso: got %h required %h", dout, exp);
    end
    mode = 2'd0;
  endtask

  task automatic test_back_to_back();
    int acc, n, base;
    logic [127:0] din;
    mode = 2'd0;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    gaps.delete();
    base = dv_cnt[0];
    din0 = din;
    v[0] = 1'b1;
    acc = 0;
    n = 0;
    while (acc < 3 && n < 2000) begin
      if (rdy[0]) acc++;
      if (acc < 3) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    v[0] = 1'b0;
    n = 0;
    while (!(rdy[0] && dv_cnt[0] >= base + 3) && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    n_cmp++;
    if (dv_cnt[0] - base != 3) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d data_out_v pulses required 3", dv_cnt[0] - base);
    end
    n_cmp++;
    if (gaps.size() != 3 || gaps[1] != 2 || gaps[2] != 2) begin
      n_err++;
      $display("FAIL b2b_cs_gap: %0d falls, gaps %0d/%0d required 3 falls, 2/2",
               gaps.size(), (gaps.size() > 1) ? gaps[1] : -1, (gaps.size() > 2) ? gaps[2] : -1);
    end
    n_cmp++;
    if (dout0 !== din) begin
      n_err++;
      $display("FAIL b2b_data: got %h required %h", dout0, din);
    end
  endtask

  task automatic test_reset_mid();
    int n, n_low, base;
    mode = 2'd0;
    n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 2000) begin @(negedge clk); n++; end
    din0 = {$urandom, $urandom, $urandom, $urandom};
    v[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    n_low = 0;
    n = 0;
    while (n_low < 50 && n < 2000) begin
      if (cs[0] === 1'b0) n_low++;
      if (n_low < 50) begin @(negedge clk); n++; end
    end
    base = dv_cnt[0];
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cs[0] !== 1'b1 || sclk[0] !== 1'b0 || mosi0 !== 4'h0 || dv[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pins: cs=%b sclk=%b mosi=%h dv=%b required 1/0/0/0",
               cs[0], sclk[0], mosi0, dv[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_ready: got %b required 1", rdy[0]);
    end
    repeat (300) @(negedge clk);
    n_cmp++;
    if (dv_cnt[0] != base) begin
      n_err++;
      $display("FAIL abort_no_dv: %0d pulses after abort required 0", dv_cnt[0] - base);
    end
  endtask

  initial begin
    reset = 1'b1;
    v = 3'b000;
    din0 = '0; din1 = '0; din2 = '0;
    mode = 2'd0;
    const_miso = 4'h0;
    for (int k = 0; k < 4; k++) begin s_word[k] = 32'h0; s_rx[k] = 32'h0; end
    test_reset();
    test_loopback_fixed();
    test_loopback_random();
    test_slave_random();
    test_miso_delay();
    test_word16();
    test_const_miso();
    test_back_to_back();
    test_reset_mid();
    test_loopback_fixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
